// File: rtl/ripple_count_checker.sv
// -----------------------------------------------------------------------------
// ripple_count_checker
//
// Registered self-check monitor for ripple_carry_counter. On every rising clk
// edge it compares the sampled count q against the previous sample plus one
// (modulo 2^WIDTH). After LOCK_CNT consecutive correct increments it declares
// lock; while locked, every bad step is reported as an error and every
// max->0 roll-over is reported as a wrap.
//
// There is no valid/ready handshake here: the upstream count is treated as a
// new sample on every rising clk edge, and every output is valid in every
// cycle (registered, changes only on the rising edge).
//
// Parameters
//   WIDTH     width of the monitored count
//   LOCK_CNT  consecutive correct increments needed for lock (1..15)
//   ERR_W     width of the saturating error counter
//
// Ports
//   clk         clock, all state updates on the rising edge
//   reset       synchronous active-high reset, highest priority
//   q           count from the upstream counter
//   enable      checking enable; low forces IDLE and drops lock
//   locked      high while the checker is in LOCKED
//   err_pulse   one-cycle pulse per error detected while locked
//   err_count   errors seen while locked, saturating at all-ones
//   wrap_pulse  one-cycle pulse per max->0 wrap seen while locked
//   wrap_count  wraps seen while locked, modulo 256
//   last_bad    q value sampled at the most recent error
// -----------------------------------------------------------------------------
module ripple_count_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] q,
    input  logic             enable,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             wrap_pulse,
    output logic [7:0]       wrap_count,
    output logic [WIDTH-1:0] last_bad
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    // The run counter is 4 bits wide, so the lock target is expressed in the
    // same width for the comparison.
    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    // Registered state
    logic [1:0]       state;
    logic [WIDTH-1:0] prev;
    logic [3:0]       run;
    logic             locked_r;
    logic             err_pulse_r;
    logic             wrap_pulse_r;
    logic [ERR_W-1:0] err_count_r;
    logic [7:0]       wrap_count_r;
    logic [WIDTH-1:0] last_bad_r;

    // Next-state values
    logic [1:0]       state_n;
    logic [WIDTH-1:0] prev_n;
    logic [3:0]       run_n;
    logic             locked_n;
    logic             err_pulse_n;
    logic             wrap_pulse_n;
    logic [ERR_W-1:0] err_count_n;
    logic [7:0]       wrap_count_n;
    logic [WIDTH-1:0] last_bad_n;

    // Expected next count. The addition is truncated to WIDTH bits so that a
    // previous value of all-ones expects zero.
    logic [WIDTH-1:0] expected;
    logic             match;
    logic             q_is_zero;
    logic [3:0]       run_inc;

    assign expected  = prev + WIDTH'(1);
    assign match     = (q == expected);
    assign q_is_zero = (q == '0);
    assign run_inc   = run + 4'd1;

    always_comb begin
        // Defaults: hold everything, pulses low.
        state_n      = state;
        prev_n       = prev;
        run_n        = run;
        locked_n     = locked_r;
        err_pulse_n  = 1'b0;
        wrap_pulse_n = 1'b0;
        err_count_n  = err_count_r;
        wrap_count_n = wrap_count_r;
        last_bad_n   = last_bad_r;

        if (!enable) begin
            // Disabling drops lock from any state; statistics are retained.
            state_n  = ST_IDLE;
            locked_n = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Capture edge only: the first sample has nothing to be
                    // compared against.
                    prev_n   = q;
                    run_n    = 4'd0;
                    state_n  = ST_ACQUIRE;
                    locked_n = 1'b0;
                end

                ST_ACQUIRE: begin
                    prev_n = q;
                    if (match) begin
                        run_n = run_inc;
                        if (run_inc == LOCK_TARGET) begin
                            state_n  = ST_LOCKED;
                            locked_n = 1'b1;
                        end
                    end else begin
                        // Mismatches while acquiring just restart the run;
                        // they are not errors because lock was never claimed.
                        run_n = 4'd0;
                    end
                end

                ST_LOCKED: begin
                    prev_n = q;
                    if (match) begin
                        if (q_is_zero) begin
                            wrap_pulse_n = 1'b1;
                            wrap_count_n = wrap_count_r + 8'd1;
                        end
                    end else begin
                        // A stalled count (q == prev) also lands here, which
                        // catches the upstream counter being held in reset.
                        err_pulse_n = 1'b1;
                        if (err_count_r != ERR_MAX) begin
                            err_count_n = err_count_r + ERR_W'(1);
                        end
                        last_bad_n = q;
                        run_n      = 4'd0;
                        state_n    = ST_ACQUIRE;
                        locked_n   = 1'b0;
                    end
                end

                default: begin
                    // Unused encoding: recover through IDLE.
                    state_n  = ST_IDLE;
                    locked_n = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            prev         <= '0;
            run          <= 4'd0;
            locked_r     <= 1'b0;
            err_pulse_r  <= 1'b0;
            wrap_pulse_r <= 1'b0;
            err_count_r  <= '0;
            wrap_count_r <= 8'd0;
            last_bad_r   <= '0;
        end else begin
            state        <= state_n;
            prev         <= prev_n;
            run          <= run_n;
            locked_r     <= locked_n;
            err_pulse_r  <= err_pulse_n;
            wrap_pulse_r <= wrap_pulse_n;
            err_count_r  <= err_count_n;
            wrap_count_r <= wrap_count_n;
            last_bad_r   <= last_bad_n;
        end
    end

    assign locked     = locked_r;
    assign err_pulse  = err_pulse_r;
    assign err_count  = err_count_r;
    assign wrap_pulse = wrap_pulse_r;
    assign wrap_count = wrap_count_r;
    assign last_bad   = last_bad_r;

endmodule

// File: tb/tb_ripple_count_checker.sv
// -----------------------------------------------------------------------------
// tb_ripple_count_checker
//
// Two checkers share one stimulus stream: u_dut with default parameters and
// u_sat with ERR_W=2 so the saturating error count is exercised. A reference
// model computes the expected outputs of both after every edge and pushes them
// into exp_q; a monitor pops one entry after each rising edge and compares.
// -----------------------------------------------------------------------------
module tb_ripple_count_checker;

    localparam int WIDTH    = 4;
    localparam int LOCK_CNT = 3;
    localparam int OW       = 1 + 1 + 1 + 8 + 2 + 8 + WIDTH;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset  = 1'b1;
    logic             enable = 1'b0;
    logic [WIDTH-1:0] q      = '0;

    logic             locked,  err_pulse,  wrap_pulse;
    logic [7:0]       err_count, wrap_count;
    logic [WIDTH-1:0] last_bad;

    logic             s_locked, s_err_pulse, s_wrap_pulse;
    logic [1:0]       s_err_count;
    logic [7:0]       s_wrap_count;
    logic [WIDTH-1:0] s_last_bad;

    ripple_count_checker #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_W(8)) u_dut (
        .clk(clk), .reset(reset), .q(q), .enable(enable),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
        .wrap_pulse(wrap_pulse), .wrap_count(wrap_count), .last_bad(last_bad)
    );

    ripple_count_checker #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_W(2)) u_sat (
        .clk(clk), .reset(reset), .q(q), .enable(enable),
        .locked(s_locked), .err_pulse(s_err_pulse), .err_count(s_err_count),
        .wrap_pulse(s_wrap_pulse), .wrap_count(s_wrap_count), .last_bad(s_last_bad)
    );

    // ---------------- scoreboard state ----------------
    logic [OW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 acquiring, 2 locked
    int m_mode = 0;
    int m_prev = 0;
    int m_run  = 0;
    int m_locked = 0, m_errp = 0, m_wrapp = 0;
    int m_ec8 = 0, m_ec2 = 0, m_wc = 0, m_lb = 0;
    int cnt = 0;  // tb-side view of the upstream count

    function automatic void model(input bit r, input bit en, input int qv);
        m_errp  = 0;
        m_wrapp = 0;
        if (r) begin
            m_mode = 0; m_prev = 0; m_run = 0; m_locked = 0;
            m_ec8 = 0; m_ec2 = 0; m_wc = 0; m_lb = 0;
        end else if (!en) begin
            m_mode = 0; m_locked = 0;
        end else if (m_mode == 0) begin
            m_prev = qv; m_run = 0; m_mode = 1;
        end else begin
            if (qv == (m_prev + 1) % (1 << WIDTH)) begin
                if (m_mode == 1) begin
                    m_run++;
                    if (m_run == LOCK_CNT) begin
                        m_mode = 2; m_locked = 1;
                    end
                end else if (qv == 0) begin
                    m_wrapp = 1;
                    m_wc = (m_wc + 1) % 256;
                end
            end else if (m_mode == 1) begin
                m_run = 0;
            end else begin
                m_errp = 1;
                m_ec8 = (m_ec8 < 255) ? m_ec8 + 1 : 255;
                m_ec2 = (m_ec2 < 3) ? m_ec2 + 1 : 3;
                m_lb = qv; m_run = 0; m_mode = 1; m_locked = 0;
            end
            m_prev = qv;
        end
    endfunction

    // ---------------- driver ----------------
    task automatic step(input bit r, input bit en, input int qv);
        logic [OW-1:0] e;
        @(negedge clk);
        reset  = r;
        enable = en;
        q      = WIDTH'(qv);
        cnt    = qv % (1 << WIDTH);
        model(r, en, cnt);
        e = {1'(m_locked), 1'(m_errp), 1'(m_wrapp), 8'(m_ec8), 2'(m_ec2),
             8'(m_wc), WIDTH'(m_lb)};
        exp_q.push_back(e);
    endtask

    // Wait for the edge that applies the last step, then settle.
    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic [OW-1:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("locked",       int'(locked),       int'(e[OW-1]));
            chk("err_pulse",    int'(err_pulse),    int'(e[OW-2]));
            chk("wrap_pulse",   int'(wrap_pulse),   int'(e[OW-3]));
            chk("err_count",    int'(err_count),    int'(e[OW-4 -: 8]));
            chk("wrap_count",   int'(wrap_count),   int'(e[WIDTH+7 -: 8]));
            chk("last_bad",     int'(last_bad),     int'(e[WIDTH-1:0]));
            chk("sat_locked",   int'(s_locked),     int'(e[OW-1]));
            chk("sat_err_pulse",int'(s_err_pulse),  int'(e[OW-2]));
            chk("sat_wrap_pulse",int'(s_wrap_pulse),int'(e[OW-3]));
            chk("sat_err_count",int'(s_err_count),  int'(e[WIDTH+9 -: 2]));
            chk("sat_wrap_count",int'(s_wrap_count),int'(e[WIDTH+7 -: 8]));
            chk("sat_last_bad", int'(s_last_bad),   int'(e[WIDTH-1:0]));
            if (err_pulse && wrap_pulse)
                chk("pulses_exclusive", 1, 0);
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    int sat_tbl[4] = '{2, 3, 3, 3};

    initial begin
        // Reset held for two edges while q moves and enable is high.
        step(1, 1, 7);
        step(1, 1, 9);
        after_edge();
        chk("reset_locked", int'(locked), 0);
        chk("reset_err_count", int'(err_count), 0);
        chk("reset_last_bad", int'(last_bad), 0);

        // Acquire: 0,1,2,3 -> lock after the edge sampling 3.
        for (int i = 0; i < 4; i++) begin
            step(0, 1, i);
            after_edge();
            chk("acq_locked", int'(locked), (i == 3) ? 1 : 0);
        end

        // Count 4..15 then 0: one wrap.
        for (int i = 4; i <= 16; i++) step(0, 1, i % 16);
        after_edge();
        chk("wrap_pulse_at_zero", int'(wrap_pulse), 1);
        chk("wrap_count_one", int'(wrap_count), 1);
        step(0, 1, 1);
        after_edge();
        chk("wrap_pulse_one_cycle", int'(wrap_pulse), 0);

        // Reach prev=5, inject 9, then 10,11,12 relocks.
        for (int i = 2; i <= 5; i++) step(0, 1, i);
        step(0, 1, 9);
        after_edge();
        chk("err_pulse_on_bad", int'(err_pulse), 1);
        chk("err_count_one", int'(err_count), 1);
        chk("last_bad_nine", int'(last_bad), 9);
        chk("unlock_on_err", int'(locked), 0);
        for (int i = 10; i <= 12; i++) step(0, 1, i);
        after_edge();
        chk("relock_at_12", int'(locked), 1);

        // Four more lock/error cycles: ERR_W=2 count reads 2,3,3,3.
        for (int k = 0; k < 4; k++) begin
            step(0, 1, cnt + 5);
            after_edge();
            chk("sat_count_seq", int'(s_err_count), sat_tbl[k]);
            chk("sat_err_pulse_fires", int'(s_err_pulse), 1);
            for (int j = 0; j < 3; j++) step(0, 1, cnt + 1);
        end

        // Drop enable for one edge, then relock in four edges.
        step(0, 0, cnt + 1);
        after_edge();
        chk("disable_unlocks", int'(locked), 0);
        chk("disable_keeps_err", int'(err_count), 5);
        for (int j = 0; j < 4; j++) step(0, 1, cnt + 1);
        after_edge();
        chk("reenable_relock", int'(locked), 1);

        // One-edge reset clears everything.
        step(1, 0, cnt + 1);
        after_edge();
        chk("reset2_err_count", int'(err_count), 0);
        chk("reset2_wrap_count", int'(wrap_count), 0);

        // Randomized phase: mostly good increments with stalls, jumps,
        // enable drops and occasional resets.
        for (int n = 0; n < 600; n++) begin
            int sel;
            int nq;
            bit r;
            bit en;
            sel = int'($urandom_range(0, 19));
            r   = ($urandom_range(0, 149) == 0);
            en  = ($urandom_range(0, 29) != 0);
            if (sel == 0)      nq = int'($urandom_range(0, 15));
            else if (sel == 1) nq = cnt;
            else               nq = cnt + 1;
            step(r, en, nq);
        end

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
